// File: rtl/biriscv_pipe_ctrl_gen.sv
// biRISC-V execution pipeline tracker: per-stage occupancy, late result insertion,
// youngest-match operand forwarding and exception squash of younger work.
module biriscv_pipe_ctrl_gen #(
  parameter int STAGES     = 3,
  parameter int LATE_STAGE = 2,
  parameter int XLEN       = 32,
  parameter int EXC_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid_i,
  input  logic             issue_accept_i,
  input  logic             issue_late_i,
  input  logic             issue_rd_valid_i,
  input  logic [4:0]       issue_rd_i,
  input  logic [XLEN-1:0]  issue_pc_i,
  input  logic [EXC_W-1:0] issue_exception_i,
  input  logic [XLEN-1:0]  e1_result_i,
  input  logic             late_valid_i,
  input  logic [XLEN-1:0]  late_result_i,
  input  logic [EXC_W-1:0] late_exception_i,
  input  logic             stall_i,
  input  logic             squash_i,
  input  logic [4:0]       fwd_ra_i,
  input  logic [4:0]       fwd_rb_i,
  output logic             fwd_ra_hit_o,
  output logic             fwd_rb_hit_o,
  output logic [XLEN-1:0]  fwd_ra_data_o,
  output logic [XLEN-1:0]  fwd_rb_data_o,
  output logic             hazard_o,
  output logic             stall_o,
  output logic             squash_o,
  output logic [3:0]       occupancy_o,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output logic [XLEN-1:0]  wb_result_o,
  output logic [XLEN-1:0]  wb_pc_o,
  output logic [EXC_W-1:0] wb_exception_o
);

  logic             valid_r [1:STAGES];
  logic             late_r  [1:STAGES];
  logic             rdv_r   [1:STAGES];
  logic [4:0]       rd_r    [1:STAGES];
  logic [XLEN-1:0]  pc_r    [1:STAGES];
  logic [XLEN-1:0]  res_r   [1:STAGES];
  logic [EXC_W-1:0] exc_r   [1:STAGES];
  logic             valid_s [1:STAGES];
  logic             late_s  [1:STAGES];
  logic             rdv_s   [1:STAGES];
  logic [4:0]       rd_s    [1:STAGES];
  logic [XLEN-1:0]  pc_s    [1:STAGES];
  logic [XLEN-1:0]  res_s   [1:STAGES];
  logic [EXC_W-1:0] exc_s   [1:STAGES];

  logic             squash_q_r, squash_q_s;
  logic             adv_s, late_hit_s, issue_ok_s, keep_s;
  logic [XLEN-1:0]  res_sel_s;
  logic [EXC_W-1:0] exc_sel_s, eexc_s;
  logic [XLEN+1:0]  fwd_a_s, fwd_b_s;
  logic [3:0]       occ_s;

  // An earlier exception always wins over one reported with the late result.
  assign late_hit_s = valid_r[LATE_STAGE] & late_r[LATE_STAGE];
  assign eexc_s     = (late_hit_s && late_valid_i && (exc_r[LATE_STAGE] == '0)) ?
                      late_exception_i : exc_r[LATE_STAGE];
  assign stall_o    = late_hit_s & ~late_valid_i;
  assign squash_o   = valid_r[LATE_STAGE] & (eexc_s != '0);
  assign adv_s      = ~stall_i & ~stall_o;

  // Next-state for every stage: hold, flush, or shift with result/exception insertion.
  always_comb begin
    issue_ok_s = issue_valid_i & issue_accept_i & ~squash_o & ~squash_q_r;
    squash_q_s = squash_q_r;
    keep_s     = 1'b1;
    res_sel_s  = '0;
    exc_sel_s  = '0;
    for (int k = 1; k <= STAGES; k++) begin
      valid_s[k] = valid_r[k];
      late_s[k]  = late_r[k];
      rdv_s[k]   = rdv_r[k];
      rd_s[k]    = rd_r[k];
      pc_s[k]    = pc_r[k];
      res_s[k]   = res_r[k];
      exc_s[k]   = exc_r[k];
    end
    if (squash_i) begin
      squash_q_s = 1'b0;
      for (int k = 1; k <= STAGES; k++) begin
        valid_s[k] = 1'b0;
        late_s[k]  = 1'b0;
        rdv_s[k]   = 1'b0;
        rd_s[k]    = 5'd0;
        pc_s[k]    = '0;
        res_s[k]   = '0;
        exc_s[k]   = '0;
      end
    end else if (adv_s) begin
      squash_q_s = squash_o;
      for (int k = 2; k <= STAGES; k++) begin
        // Stages younger than the faulting one become bubbles on a squash.
        keep_s    = !(squash_o && (k <= LATE_STAGE));
        res_sel_s = ((k == 2) && valid_r[1] && !late_r[1]) ? e1_result_i : res_r[k-1];
        res_sel_s = ((k == LATE_STAGE + 1) && late_hit_s) ? late_result_i : res_sel_s;
        exc_sel_s = ((k == LATE_STAGE + 1) && late_hit_s) ? eexc_s : exc_r[k-1];
        valid_s[k] = valid_r[k-1] & keep_s;
        late_s[k]  = late_r[k-1] & keep_s;
        rdv_s[k]   = rdv_r[k-1] & keep_s & !(squash_o && (k == LATE_STAGE + 1));
        rd_s[k]    = keep_s ? rd_r[k-1] : 5'd0;
        pc_s[k]    = keep_s ? pc_r[k-1] : '0;
        res_s[k]   = keep_s ? res_sel_s : '0;
        exc_s[k]   = keep_s ? exc_sel_s : '0;
      end
      valid_s[1] = issue_ok_s;
      late_s[1]  = issue_ok_s & issue_late_i;
      rdv_s[1]   = issue_ok_s & issue_rd_valid_i;
      rd_s[1]    = issue_ok_s ? issue_rd_i : 5'd0;
      pc_s[1]    = issue_ok_s ? issue_pc_i : '0;
      res_s[1]   = '0;
      exc_s[1]   = issue_ok_s ? issue_exception_i : '0;
    end else begin
      squash_q_s = squash_q_r;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_q_r <= 1'b0;
      for (int k = 1; k <= STAGES; k++) begin
        valid_r[k] <= 1'b0;
        late_r[k]  <= 1'b0;
        rdv_r[k]   <= 1'b0;
        rd_r[k]    <= 5'd0;
        pc_r[k]    <= '0;
        res_r[k]   <= '0;
        exc_r[k]   <= '0;
      end
    end else begin
      squash_q_r <= squash_q_s;
      for (int k = 1; k <= STAGES; k++) begin
        valid_r[k] <= valid_s[k];
        late_r[k]  <= late_s[k];
        rdv_r[k]   <= rdv_s[k];
        rd_r[k]    <= rd_s[k];
        pc_r[k]    <= pc_s[k];
        res_r[k]   <= res_s[k];
        exc_r[k]   <= exc_s[k];
      end
    end
  end

  // Returns {hit, hazard, data} for the youngest in-flight writer of src.
  function automatic logic [XLEN+1:0] fwd_lookup(input logic [4:0] src);
    logic            found, hit, haz;
    logic [XLEN-1:0] data;
    int              win;
    found = 1'b0;
    hit   = 1'b0;
    haz   = 1'b0;
    data  = '0;
    win   = 1;
    for (int k = STAGES; k >= 1; k--) begin
      if ((src != 5'd0) && valid_r[k] && rdv_r[k] && (rd_r[k] == src) && (exc_r[k] == '0)) begin
        found = 1'b1;
        win   = k;
      end
    end
    if (found) begin
      if ((win > LATE_STAGE) || (!late_r[win] && (win >= 2))) begin
        hit  = 1'b1;
        data = res_r[win];
      end else if (!late_r[win]) begin
        hit  = 1'b1;
        data = e1_result_i;
      end else if (win < LATE_STAGE) begin
        haz = 1'b1;
      end else if (late_valid_i) begin
        hit  = 1'b1;
        data = late_result_i;
      end else begin
        haz = 1'b1;
      end
    end
    return {hit, haz, data};
  endfunction

  // Forwarding lookups and stage occupancy count.
  always_comb begin
    fwd_a_s = fwd_lookup(fwd_ra_i);
    fwd_b_s = fwd_lookup(fwd_rb_i);
    occ_s   = 4'd0;
    for (int k = 1; k <= STAGES; k++) begin
      occ_s = occ_s + {3'b000, valid_r[k]};
    end
  end

  assign fwd_ra_hit_o   = fwd_a_s[XLEN+1];
  assign fwd_rb_hit_o   = fwd_b_s[XLEN+1];
  assign fwd_ra_data_o  = fwd_a_s[XLEN-1:0];
  assign fwd_rb_data_o  = fwd_b_s[XLEN-1:0];
  assign hazard_o       = fwd_a_s[XLEN] | fwd_b_s[XLEN];
  assign occupancy_o    = occ_s;
  assign wb_valid_o     = valid_r[STAGES] & adv_s;
  assign wb_rd_o        = (wb_valid_o && rdv_r[STAGES]) ? rd_r[STAGES] : 5'd0;
  assign wb_result_o    = res_r[STAGES];
  assign wb_pc_o        = pc_r[STAGES];
  assign wb_exception_o = exc_r[STAGES];

endmodule

// File: tb/tb_biriscv_pipe_ctrl_gen.sv
// Self-checking bench for biriscv_pipe_ctrl_gen: directed scenarios plus a random run
// compared against a stage-list reference model.
module tb_biriscv_pipe_ctrl_gen;
  localparam int ST = 3;
  localparam int LS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_i, issue_accept_i, issue_late_i, issue_rd_valid_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] issue_pc_i, e1_result_i, late_result_i;
  logic [5:0]  issue_exception_i, late_exception_i;
  logic        late_valid_i, stall_i, squash_i;
  logic [4:0]  fwd_ra_i, fwd_rb_i;
  logic        fwd_ra_hit_o, fwd_rb_hit_o, hazard_o, stall_o, squash_o, wb_valid_o;
  logic [31:0] fwd_ra_data_o, fwd_rb_data_o, wb_result_o, wb_pc_o;
  logic [3:0]  occupancy_o;
  logic [4:0]  wb_rd_o;
  logic [5:0]  wb_exception_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  biriscv_pipe_ctrl_gen #(.STAGES(ST), .LATE_STAGE(LS), .XLEN(32), .EXC_W(6)) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_accept_i(issue_accept_i), .issue_late_i(issue_late_i),
    .issue_rd_valid_i(issue_rd_valid_i), .issue_rd_i(issue_rd_i), .issue_pc_i(issue_pc_i),
    .issue_exception_i(issue_exception_i), .e1_result_i(e1_result_i),
    .late_valid_i(late_valid_i), .late_result_i(late_result_i), .late_exception_i(late_exception_i),
    .stall_i(stall_i), .squash_i(squash_i), .fwd_ra_i(fwd_ra_i), .fwd_rb_i(fwd_rb_i),
    .fwd_ra_hit_o(fwd_ra_hit_o), .fwd_rb_hit_o(fwd_rb_hit_o),
    .fwd_ra_data_o(fwd_ra_data_o), .fwd_rb_data_o(fwd_rb_data_o),
    .hazard_o(hazard_o), .stall_o(stall_o), .squash_o(squash_o), .occupancy_o(occupancy_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o),
    .wb_pc_o(wb_pc_o), .wb_exception_o(wb_exception_o)
  );

  // Reference model: a list of in-flight instructions, youngest at index 1.
  typedef struct packed {
    logic        v, late, rdv;
    logic [4:0]  rd;
    logic [31:0] pc, res;
    logic [5:0]  exc;
  } ent_t;

  ent_t        m [1:ST];
  logic        m_sq_q;
  logic        e_stall, e_squash, e_hazard, e_ra_hit, e_rb_hit, e_wb_valid, e_ha, e_hb;
  logic [31:0] e_ra_data, e_rb_data;
  logic [4:0]  e_wb_rd;
  logic [3:0]  e_occ;
  logic [5:0]  e_eexc;

  task automatic model_fwd(input logic [4:0] s, output logic hit, output logic haz, output logic [31:0] d);
    int w = 0;
    hit = 1'b0; haz = 1'b0; d = 32'd0;
    if (s != 5'd0)
      for (int k = 1; k <= ST; k++)
        if (w == 0 && m[k].v && m[k].rdv && m[k].rd == s && m[k].exc == 6'd0) w = k;
    if (w != 0) begin
      if (!m[w].late) begin hit = 1'b1; d = (w == 1) ? e1_result_i : m[w].res; end
      else if (w > LS) begin hit = 1'b1; d = m[w].res; end
      else if (w == LS && late_valid_i) begin hit = 1'b1; d = late_result_i; end
      else haz = 1'b1;
    end
  endtask

  task automatic model_eval();
    e_stall  = m[LS].v && m[LS].late && !late_valid_i;
    e_eexc   = m[LS].exc;
    if (e_eexc == 6'd0 && m[LS].late && late_valid_i) e_eexc = late_exception_i;
    e_squash = m[LS].v && (e_eexc != 6'd0);
    model_fwd(fwd_ra_i, e_ra_hit, e_ha, e_ra_data);
    model_fwd(fwd_rb_i, e_rb_hit, e_hb, e_rb_data);
    e_hazard   = e_ha | e_hb;
    e_wb_valid = m[ST].v && !stall_i && !e_stall;
    e_wb_rd    = (e_wb_valid && m[ST].rdv) ? m[ST].rd : 5'd0;
    e_occ = 4'd0;
    for (int k = 1; k <= ST; k++) e_occ = e_occ + (m[k].v ? 4'd1 : 4'd0);
  endtask

  task automatic model_step();
    ent_t n [1:ST];
    model_eval();
    if (rst || squash_i) begin
      for (int k = 1; k <= ST; k++) m[k] = '0;
      m_sq_q = 1'b0;
    end else if (!stall_i && !e_stall) begin
      for (int k = 2; k <= ST; k++) n[k] = m[k-1];
      if (m[1].v && !m[1].late) n[2].res = e1_result_i;
      if (m[LS].v && m[LS].late) begin n[LS+1].res = late_result_i; n[LS+1].exc = e_eexc; end
      if (e_squash) begin
        n[LS+1].rdv = 1'b0;
        for (int k = 2; k <= LS; k++) n[k] = '0;
      end
      n[1] = '0;
      if (issue_valid_i && issue_accept_i && !e_squash && !m_sq_q) begin
        n[1].v = 1'b1; n[1].late = issue_late_i; n[1].rdv = issue_rd_valid_i;
        n[1].rd = issue_rd_i; n[1].pc = issue_pc_i; n[1].exc = issue_exception_i;
      end
      m = n;
      m_sq_q = e_squash;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 1'b0; issue_accept_i = 1'b0; issue_late_i = 1'b0; issue_rd_valid_i = 1'b0;
    issue_rd_i = 5'd0; issue_pc_i = 32'd0; issue_exception_i = 6'd0; e1_result_i = 32'd0;
    late_valid_i = 1'b0; late_result_i = 32'd0; late_exception_i = 6'd0;
    stall_i = 1'b0; squash_i = 1'b0; fwd_ra_i = 5'd0; fwd_rb_i = 5'd0;
  endtask

  task automatic issue(input logic late, input logic [4:0] rd, input logic [31:0] pc);
    issue_valid_i = 1'b1; issue_accept_i = 1'b1; issue_late_i = late;
    issue_rd_valid_i = 1'b1; issue_rd_i = rd; issue_pc_i = pc;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; cyc(); cyc();
    total++; if (occupancy_o !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
    total++; if ({wb_valid_o, stall_o, squash_o, hazard_o, fwd_ra_hit_o} !== 5'd0) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", {wb_valid_o, stall_o, squash_o, hazard_o, fwd_ra_hit_o}); end
    total++; if ({wb_result_o, wb_pc_o, wb_rd_o} !== 69'd0) begin bad++; $display("FAIL reset_wb got=%h exp=0", {wb_result_o, wb_pc_o, wb_rd_o}); end
    rst = 1'b0;
  endtask

  task automatic test_alu_flow();
    idle(); issue(1'b0, 5'd5, 32'h100); cyc();
    idle(); e1_result_i = 32'h2A; #1;
    total++; if (occupancy_o !== 4'd1) begin bad++; $display("FAIL alu_occ1 got=%0d exp=1", occupancy_o); end
    cyc(); e1_result_i = 32'd0; cyc();
    total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd5) begin bad++; $display("FAIL alu_wb got=%b/%0d exp=1/5", wb_valid_o, wb_rd_o); end
    total++; if (wb_result_o !== 32'h2A || wb_pc_o !== 32'h100) begin bad++; $display("FAIL alu_data got=%h/%h exp=2a/100", wb_result_o, wb_pc_o); end
    cyc();
    total++; if (occupancy_o !== 4'd0) begin bad++; $display("FAIL alu_occ0 got=%0d exp=0", occupancy_o); end
  endtask

  task automatic test_late_stall();
    idle(); issue(1'b1, 5'd7, 32'h200); cyc();
    idle(); cyc();
    for (int i = 0; i < 4; i++) begin
      total++; if (stall_o !== 1'b1 || occupancy_o !== 4'd1 || wb_valid_o !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%b/%0d exp=1/1", i, stall_o, occupancy_o); end
      cyc();
    end
    late_valid_i = 1'b1; late_result_i = 32'hDEADBEEF; #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", stall_o); end
    cyc(); idle(); #1;
    total++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'hDEADBEEF || wb_rd_o !== 5'd7) begin bad++; $display("FAIL stall_wb got=%b/%h/%0d exp=1/deadbeef/7", wb_valid_o, wb_result_o, wb_rd_o); end
    cyc();
  endtask

  task automatic test_forward();
    idle(); issue(1'b0, 5'd5, 32'h300); cyc();
    e1_result_i = 32'h11; cyc();
    idle(); e1_result_i = 32'h22; fwd_ra_i = 5'd5; fwd_rb_i = 5'd0; #1;
    total++; if (fwd_ra_hit_o !== 1'b1 || fwd_ra_data_o !== 32'h22) begin bad++; $display("FAIL fwd_young got=%b/%h exp=1/22", fwd_ra_hit_o, fwd_ra_data_o); end
    total++; if (fwd_rb_hit_o !== 1'b0 || hazard_o !== 1'b0) begin bad++; $display("FAIL fwd_x0 got=%b/%b exp=0/0", fwd_rb_hit_o, hazard_o); end
    cyc(); e1_result_i = 32'h99; #1;
    total++; if (fwd_ra_hit_o !== 1'b1 || fwd_ra_data_o !== 32'h22) begin bad++; $display("FAIL fwd_s2 got=%b/%h exp=1/22", fwd_ra_hit_o, fwd_ra_data_o); end
    idle(); cyc(); cyc(); cyc();
  endtask

  task automatic test_hazard();
    idle(); issue(1'b1, 5'd7, 32'h400); cyc();
    idle(); fwd_rb_i = 5'd7; #1;
    total++; if (hazard_o !== 1'b1 || fwd_rb_hit_o !== 1'b0) begin bad++; $display("FAIL haz_s1 got=%b/%b exp=1/0", hazard_o, fwd_rb_hit_o); end
    cyc();
    late_valid_i = 1'b1; late_result_i = 32'h55; #1;
    total++; if (fwd_rb_hit_o !== 1'b1 || fwd_rb_data_o !== 32'h55 || hazard_o !== 1'b0) begin bad++; $display("FAIL haz_late got=%b/%h/%b exp=1/55/0", fwd_rb_hit_o, fwd_rb_data_o, hazard_o); end
    late_valid_i = 1'b0; #1;
    total++; if (hazard_o !== 1'b1 || stall_o !== 1'b1) begin bad++; $display("FAIL haz_wait got=%b/%b exp=1/1", hazard_o, stall_o); end
    late_valid_i = 1'b1; cyc();
    late_valid_i = 1'b0; #1;
    total++; if (fwd_rb_hit_o !== 1'b1 || fwd_rb_data_o !== 32'h55) begin bad++; $display("FAIL haz_s3 got=%b/%h exp=1/55", fwd_rb_hit_o, fwd_rb_data_o); end
    idle(); cyc();
  endtask

  task automatic test_exception();
    idle(); issue(1'b1, 5'd9, 32'h500); cyc();
    issue(1'b0, 5'd3, 32'h504); cyc();
    issue(1'b0, 5'd4, 32'h508); late_valid_i = 1'b1; late_exception_i = 6'h04; late_result_i = 32'h77; #1;
    total++; if (squash_o !== 1'b1 || stall_o !== 1'b0) begin bad++; $display("FAIL exc_squash got=%b/%b exp=1/0", squash_o, stall_o); end
    cyc(); late_valid_i = 1'b0; late_exception_i = 6'd0; #1;
    total++; if (wb_valid_o !== 1'b1 || wb_exception_o !== 6'h04 || wb_rd_o !== 5'd0) begin bad++; $display("FAIL exc_wb got=%b/%h/%0d exp=1/04/0", wb_valid_o, wb_exception_o, wb_rd_o); end
    total++; if (occupancy_o !== 4'd1) begin bad++; $display("FAIL exc_bubble got=%0d exp=1", occupancy_o); end
    cyc();
    total++; if (occupancy_o !== 4'd0) begin bad++; $display("FAIL exc_block2 got=%0d exp=0", occupancy_o); end
    cyc(); idle(); #1;
    total++; if (occupancy_o !== 4'd1) begin bad++; $display("FAIL exc_reissue got=%0d exp=1", occupancy_o); end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++) begin issue(1'b0, 5'(i + 1), 32'h600 + 32'(i)); cyc(); end
    idle(); #1;
    total++; if (occupancy_o !== 4'd3) begin bad++; $display("FAIL flush_fill got=%0d exp=3", occupancy_o); end
    stall_i = 1'b1; squash_i = 1'b1; cyc();
    idle(); #1;
    total++; if (occupancy_o !== 4'd0 || wb_valid_o !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0d/%b exp=0/0", occupancy_o, wb_valid_o); end
  endtask

  task automatic test_reset_in_stall();
    idle(); issue(1'b1, 5'd7, 32'h700); cyc();
    issue(1'b0, 5'd8, 32'h704); cyc();
    idle(); #1;
    total++; if (stall_o !== 1'b1 || occupancy_o !== 4'd2) begin bad++; $display("FAIL rstall_pre got=%b/%0d exp=1/2", stall_o, occupancy_o); end
    rst = 1'b1; cyc();
    total++; if ({stall_o, squash_o, wb_valid_o, occupancy_o, wb_pc_o} !== 39'd0) begin bad++; $display("FAIL rstall_clear got=%h exp=0", {stall_o, squash_o, wb_valid_o, occupancy_o, wb_pc_o}); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst               = ($urandom_range(0, 99) == 0);
      issue_valid_i     = ($urandom_range(0, 3) != 0);
      issue_accept_i    = ($urandom_range(0, 7) != 0);
      issue_late_i      = ($urandom_range(0, 2) == 0);
      issue_rd_valid_i  = ($urandom_range(0, 3) != 0);
      issue_rd_i        = 5'($urandom_range(0, 7));
      issue_pc_i        = $urandom;
      issue_exception_i = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      e1_result_i       = $urandom;
      late_valid_i      = $urandom_range(0, 1) == 1;
      late_result_i     = $urandom;
      late_exception_i  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      stall_i           = ($urandom_range(0, 7) == 0);
      squash_i          = ($urandom_range(0, 31) == 0);
      fwd_ra_i          = 5'($urandom_range(0, 7));
      fwd_rb_i          = 5'($urandom_range(0, 7));
      #1; model_eval();
      total++; if ({stall_o, squash_o, hazard_o, occupancy_o} !== {e_stall, e_squash, e_hazard, e_occ}) begin bad++; $display("FAIL rand_ctrl i=%0d got=%b exp=%b", i, {stall_o, squash_o, hazard_o, occupancy_o}, {e_stall, e_squash, e_hazard, e_occ}); end
      total++; if ({fwd_ra_hit_o, fwd_ra_data_o, fwd_rb_hit_o, fwd_rb_data_o} !== {e_ra_hit, e_ra_data, e_rb_hit, e_rb_data}) begin bad++; $display("FAIL rand_fwd i=%0d got=%h exp=%h", i, {fwd_ra_hit_o, fwd_ra_data_o, fwd_rb_hit_o, fwd_rb_data_o}, {e_ra_hit, e_ra_data, e_rb_hit, e_rb_data}); end
      total++; if ({wb_valid_o, wb_rd_o, wb_result_o, wb_pc_o, wb_exception_o} !== {e_wb_valid, e_wb_rd, m[ST].res, m[ST].pc, m[ST].exc}) begin bad++; $display("FAIL rand_wb i=%0d got=%h exp=%h", i, {wb_valid_o, wb_rd_o, wb_result_o, wb_pc_o, wb_exception_o}, {e_wb_valid, e_wb_rd, m[ST].res, m[ST].pc, m[ST].exc}); end
      cyc();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 1; k <= ST; k++) m[k] = '0;
    m_sq_q = 1'b0;
    rst = 1'b1;
    idle();
    #1;
    test_reset();
    test_alu_flow();
    test_late_stall();
    test_forward();
    test_hazard();
    test_exception();
    test_flush();
    test_reset_in_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/biriscv_pipe_ctrl_gen.md
Name: biriscv_pipe_ctrl_gen

Overview:
- Parametrised in-order execution-pipeline tracker for the biRISC-V core.
- Tracks up to STAGES in-flight instructions from issue to writeback: per-stage valid, rd, pc, result and exception.
- Inserts late results (load/mul) at a configurable stage and stalls while they are missing.
- Provides youngest-match operand forwarding with hazard detection, and squashes younger work on an exception.

Parameters:
- STAGES, 3, pipeline depth after issue (E1..E[STAGES]); stage STAGES is WB; legal 2..8.
- LATE_STAGE, 2, stage at which late results/exceptions are supplied; legal 1..STAGES-1.
- XLEN, 32, data/pc width.
- EXC_W, 6, exception code width; 0 = none.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid_i  in  1  issue slot holds an instruction
- issue_accept_i  in  1  issue handshake accepted
- issue_late_i  in  1  result arrives at LATE_STAGE (load/mul)
- issue_rd_valid_i  in  1  instruction writes rd
- issue_rd_i  in  5  destination register
- issue_pc_i  in  XLEN  instruction pc
- issue_exception_i  in  EXC_W  frontend exception
- e1_result_i  in  XLEN  ALU result for the instruction in stage 1
- late_valid_i  in  1  late result valid for stage LATE_STAGE
- late_result_i  in  XLEN  late result
- late_exception_i  in  EXC_W  late exception (qualified by late_valid_i)
- stall_i  in  1  external stall
- squash_i  in  1  external flush of all stages
- fwd_ra_i, fwd_rb_i  in  5  source registers to look up
- fwd_ra_hit_o, fwd_rb_hit_o  out  1  forward value valid
- fwd_ra_data_o, fwd_rb_data_o  out  XLEN  forward value
- hazard_o  out  1  a source depends on an unready late result
- stall_o  out  1  internal stall (late result missing)
- squash_o  out  1  exception squash of younger stages
- occupancy_o  out  4  count of valid stages
- wb_valid_o  out  1  WB instruction commits this cycle
- wb_rd_o  out  5  WB destination; 0 if no write
- wb_result_o  out  XLEN  WB result
- wb_pc_o  out  XLEN  WB pc
- wb_exception_o  out  EXC_W  WB exception code

Behaviour:
- Reset: all stage registers, squash_q and every output are 0.
- adv = ~stall_i & ~stall_o.
- stall_o = S[LATE_STAGE].valid & late & ~late_valid_i.
- Stage k is entry S[k] (valid, late, rd_valid, rd, pc, result, exc).
- squash_i has priority over everything: at the next edge all S[1..STAGES] are cleared, even if stalled.
- When ~adv, no stage changes.
- On adv:
  - S[1] loads issue fields if issue_valid_i & issue_accept_i & ~squash_o & ~squash_q; otherwise it becomes a bubble.
  - S[k] <= S[k-1] for k ≥ 2.
  - The result for S[1]→S[2] is e1_result_i unless the entry is late.
  - For S[LATE_STAGE]→S[LATE_STAGE+1] on a late entry: result <= late_result_i; exc <= late_exception_i only if the existing exc == 0 (an earlier exception wins).
  - If LATE_STAGE == 1, the late mux has priority over e1_result_i.
- Effective exception at LATE_STAGE: eexc = S[LATE_STAGE].exc, or late_exception_i when late & late_valid_i & exc == 0.
- squash_o = S[LATE_STAGE].valid & (eexc != 0).
- On adv with squash_o:
  - The faulting entry advances with rd_valid cleared.
  - All stages 1..LATE_STAGE-1 advance as bubbles.
  - Issue is blocked.
  - squash_q <= 1 for one adv cycle and blocks issue again.
  - squash_q clears on the next adv.
- Forwarding, per source s, evaluated combinationally:
  - s == 0 never hits.
  - Candidates are valid stages with rd_valid & rd == s & exc == 0; the youngest (lowest k) wins.
  - Winner with k > LATE_STAGE, or a non-late winner with k ≥ 2: hit, data = S[k].result.
  - Non-late winner at k == 1: hit, data = e1_result_i.
  - Late winner at k < LATE_STAGE: no hit; hazard.
  - Late winner at k == LATE_STAGE: hit with late_result_i if late_valid_i, else hazard.
  - hazard_o = OR of both sources' hazards.
- Writeback:
  - wb_valid_o = S[STAGES].valid & ~stall_i & ~stall_o.
  - wb_rd_o = rd when wb_valid_o & rd_valid, else 0.
  - wb_result_o, wb_pc_o and wb_exception_o come straight from S[STAGES].
- occupancy_o = popcount of S[*].valid, zero-extended.
- Latency: an instruction accepted at edge t is at WB in the cycle after edge t+STAGES-1, i.e. it commits STAGES cycles after acceptance with no stalls.
- Simultaneous squash_i and squash_o: squash_i wins and the faulting entry is dropped.
- rst asserted mid-stall clears everything on the next edge.

Test Plan:
- ALU flow (STAGES=3, LATE_STAGE=2): accept addi x5 at pc 0x100 with e1_result_i=0x2A → 3 cycles later wb_valid_o=1, wb_rd_o=5, wb_result_o=0x2A, wb_pc_o=0x100; occupancy_o goes 1 then 0.
- Late stall: load x7 in S[2] with late_valid_i low for 4 cycles → stall_o=1 for 4 cycles and all stages frozen; late_result_i=0xDEADBEEF in the 5th cycle → wb_result_o=0xDEADBEEF on the next cycle.
- Forward priority: x5 in S[2] (result 0x11) and x5 in S[1] with e1_result_i=0x22; fwd_ra_i=5 → fwd_ra_hit_o=1, data 0x22. fwd_rb_i=0 → hit 0.
- Hazard: late x7 in S[1], fwd_rb_i=7 → hazard_o=1, fwd_rb_hit_o=0. After it reaches S[2] with late_valid_i=1 and result 0x55 → hit=1, data 0x55, hazard_o=0.
- Exception squash: late entry in S[2] gets late_exception_i=0x04 while S[1] is valid → squash_o=1; S[1] becomes a bubble; issue blocked 2 cycles; WB shows wb_exception_o=0x04, wb_rd_o=0.
- Flush/reset: squash_i while stall_i=1 with 3 valid stages → occupancy_o=0 after one edge. rst during a late stall → all outputs 0 next cycle.
